regfile_lanes: RTL

- Parametrised successor to the CPU's 8x16 general-purpose register file.
- Generalises data width, register count and write granularity (per-lane byte enables replace the fixed full/low/high write modes).
- Adds optional write-through bypass, an optional hardwired-zero register 0, and a per-register pending scoreboard for multi-cycle producers such as load and multiply.
- Sits between decode (select lines) and ALU (operands) in the pipeline.

---
 rtl/regfile_lanes_if.sv | 40 ++++
 rtl/regfile_lanes.sv | 124 ++++++++++++
 2 files changed

// File: rtl/regfile_lanes_if.sv
// Bus between decode/ALU and the lane-writable register file.
// The master drives selects, write data and reserve requests; the slave
// returns registered operands, busy flags and the pending scoreboard.
interface regfile_lanes_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int LANE_W = 8
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int NLANE = DATA_W / LANE_W;

  logic                I_enable;
  logic [ADDR_W-1:0]   I_rA_select;
  logic [ADDR_W-1:0]   I_rB_select;
  logic [ADDR_W-1:0]   I_rD_select;
  logic [DATA_W-1:0]   I_rD_in;
  logic                I_rD_write;
  logic [NLANE-1:0]    I_rD_lane_en;
  logic [ADDR_W-1:0]   I_res_select;
  logic                I_res;

  logic [DATA_W-1:0]   O_rA_out;
  logic [DATA_W-1:0]   O_rB_out;
  logic                O_rA_busy;
  logic                O_rB_busy;
  logic [NREG-1:0]     O_pending;
  logic                O_res_conflict;

  modport master (
    output I_enable, I_rA_select, I_rB_select, I_rD_select, I_rD_in,
           I_rD_write, I_rD_lane_en, I_res_select, I_res,
    input  O_rA_out, O_rB_out, O_rA_busy, O_rB_busy, O_pending, O_res_conflict
  );

  modport slave (
    input  I_enable, I_rA_select, I_rB_select, I_rD_select, I_rD_in,
           I_rD_write, I_rD_lane_en, I_res_select, I_res,
    output O_rA_out, O_rB_out, O_rA_busy, O_rB_busy, O_pending, O_res_conflict
  );
endinterface

// File: rtl/regfile_lanes.sv
// Parametrised register file with per-lane write enables, optional
// write-through bypass, optional hardwired-zero r0 and a per-register
// pending scoreboard for multi-cycle producers.
module regfile_lanes #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int LANE_W   = 8,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic           I_clk,
  input  logic           I_reset,
  regfile_lanes_if.slave bus
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int NLANE = DATA_W / LANE_W;

  // Architectural state
  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   pend_q, pend_d;

  // Registered outputs
  logic [DATA_W-1:0] ra_q, ra_d;
  logic [DATA_W-1:0] rb_q, rb_d;
  logic              ra_busy_q, ra_busy_d;
  logic              rb_busy_q, rb_busy_d;
  logic              conflict_q, conflict_d;

  // Qualified strobes
  logic              wr_en;      // write completion (also clears pending)
  logic              wr_zero;    // write aimed at hardwired r0
  logic              res_zero;   // reserve aimed at hardwired r0
  logic              res_en;     // reserve that actually takes effect
  logic [DATA_W-1:0] old_w;
  logic [DATA_W-1:0] merged_w;

  // Decode write/reserve qualifiers; r0 is exempt when hardwired to zero
  always_comb begin
    wr_zero  = (ZERO_REG != 0) && (bus.I_rD_select == '0);
    res_zero = (ZERO_REG != 0) && (bus.I_res_select == '0);
    wr_en    = bus.I_enable && bus.I_rD_write;
    res_en   = bus.I_enable && bus.I_res && !res_zero;
    old_w    = regs_q[bus.I_rD_select];
  end

  // Lane merge: enabled lanes take new data, others keep the stored value
  for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
    assign merged_w[gi*LANE_W +: LANE_W] = bus.I_rD_lane_en[gi]
                                         ? bus.I_rD_in[gi*LANE_W +: LANE_W]
                                         : old_w[gi*LANE_W +: LANE_W];
  end

  // Scoreboard next state: write clears, reserve sets, set wins on a tie
  always_comb begin
    pend_d = pend_q;
    if (wr_en) pend_d[bus.I_rD_select] = 1'b0;
    if (res_en) pend_d[bus.I_res_select] = 1'b1;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
    conflict_d = res_en && pend_q[bus.I_res_select] &&
                 !(wr_en && (bus.I_rD_select == bus.I_res_select));
  end

  // Port A operand and busy; bypass forwards the merged write and next pending
  always_comb begin
    if ((ZERO_REG != 0) && (bus.I_rA_select == '0))
      ra_d = '0;
    else if ((BYPASS != 0) && wr_en && (bus.I_rA_select == bus.I_rD_select))
      ra_d = merged_w;
    else
      ra_d = regs_q[bus.I_rA_select];
    ra_busy_d = (BYPASS != 0) ? pend_d[bus.I_rA_select] : pend_q[bus.I_rA_select];
  end

  // Port B operand and busy, identical policy to port A
  always_comb begin
    if ((ZERO_REG != 0) && (bus.I_rB_select == '0))
      rb_d = '0;
    else if ((BYPASS != 0) && wr_en && (bus.I_rB_select == bus.I_rD_select))
      rb_d = merged_w;
    else
      rb_d = regs_q[bus.I_rB_select];
    rb_busy_d = (BYPASS != 0) ? pend_d[bus.I_rB_select] : pend_q[bus.I_rB_select];
  end

  // Register array update; reset wipes every register so no partial write survives
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_en && !wr_zero && (bus.I_rD_select == ADDR_W'(i)))
          regs_q[i] <= merged_w;
      end
    end
  end

  // Outputs and scoreboard; a disabled cycle holds everything but drops conflict
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      pend_q     <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      ra_busy_q  <= 1'b0;
      rb_busy_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
      if (bus.I_enable) begin
        pend_q    <= pend_d;
        ra_q      <= ra_d;
        rb_q      <= rb_d;
        ra_busy_q <= ra_busy_d;
        rb_busy_q <= rb_busy_d;
      end
    end
  end

  assign bus.O_rA_out       = ra_q;
  assign bus.O_rB_out       = rb_q;
  assign bus.O_rA_busy      = ra_busy_q;
  assign bus.O_rB_busy      = rb_busy_q;
  assign bus.O_pending      = pend_q;
  assign bus.O_res_conflict = conflict_q;
endmodule
